// File: rtl/control_seq.sv
// Multi-cycle CPU control sequencer: walks each instruction through fetch, register load,
// execute, register store and next-PC, with memory timeout, multi-cycle ALU, HALT and traps.
module control_seq #(
  parameter int unsigned OPW        = 4,
  parameter int unsigned ALU_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned TW         = 5,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned OP_LOAD    = 0,
  parameter int unsigned OP_STORE   = 1,
  parameter int unsigned OP_LOADLO  = 2,
  parameter int unsigned OP_LOADHI  = 3,
  parameter int unsigned OP_IN      = 4,
  parameter int unsigned OP_OUT     = 5,
  parameter int unsigned OP_JMP     = 6,
  parameter int unsigned OP_BR      = 7,
  parameter int unsigned OP_HALT    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   opcode,
  input  logic             isaluop,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             do_fetch,
  output logic             do_regload,
  output logic             do_aluop,
  output logic             do_load,
  output logic             do_store,
  output logic             do_regstore,
  output logic             do_next,
  output logic             mem_req,
  output logic             halted,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned AW = (ALU_CYCLES > 1) ? $clog2(ALU_CYCLES) : 1;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_REGLOAD  = 4'd1,
    ST_ALUOP    = 4'd2,
    ST_REGSTORE = 4'd3,
    ST_LOAD     = 4'd4,
    ST_STORE    = 4'd5,
    ST_NEXT     = 4'd6,
    ST_HALT     = 4'd7,
    ST_ERROR    = 4'd8
  } state_t;

  state_t           cur_st, st_nxt;
  logic [TW-1:0]    wait_cnt, wait_nxt;
  logic [AW-1:0]    alu_cnt, alu_nxt;
  logic [1:0]       err_q, err_nxt;
  logic [CNT_W-1:0] ret_q, ret_nxt;

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st   <= ST_FETCH;
      wait_cnt <= '0;
      alu_cnt  <= '0;
      err_q    <= 2'd0;
      ret_q    <= '0;
    end else begin
      cur_st   <= st_nxt;
      wait_cnt <= wait_nxt;
      alu_cnt  <= alu_nxt;
      err_q    <= err_nxt;
      ret_q    <= ret_nxt;
    end
  end

  // Next-state and counter updates
  always_comb begin
    st_nxt   = cur_st;
    wait_nxt = wait_cnt;
    alu_nxt  = alu_cnt;
    err_nxt  = err_q;
    ret_nxt  = ret_q;
    case (cur_st)
      ST_FETCH, ST_LOAD, ST_STORE: begin
        if (mem_ready) begin
          wait_nxt = '0;
          if (cur_st == ST_FETCH)     st_nxt = ST_REGLOAD;
          else if (cur_st == ST_LOAD) st_nxt = ST_REGSTORE;
          else                        st_nxt = ST_NEXT;
        end else if ((TIMEOUT != 0) && (wait_cnt == TW'(TIMEOUT - 1))) begin
          st_nxt  = ST_ERROR;
          err_nxt = 2'd2;
        end else begin
          wait_nxt = wait_cnt + TW'(1);
        end
      end
      ST_REGLOAD: begin
        // isaluop takes priority over the opcode field
        if (isaluop)
          st_nxt = ST_ALUOP;
        else if (opcode == OPW'(OP_LOAD) || opcode == OPW'(OP_IN))
          st_nxt = ST_LOAD;
        else if (opcode == OPW'(OP_STORE) || opcode == OPW'(OP_OUT))
          st_nxt = ST_STORE;
        else if (opcode == OPW'(OP_LOADLO) || opcode == OPW'(OP_LOADHI))
          st_nxt = ST_REGSTORE;
        else if (opcode == OPW'(OP_JMP) || opcode == OPW'(OP_BR))
          st_nxt = ST_NEXT;
        else if (opcode == OPW'(OP_HALT))
          st_nxt = ST_HALT;
        else begin
          st_nxt  = ST_ERROR;
          err_nxt = 2'd1;
        end
      end
      ST_ALUOP: begin
        if (alu_cnt == AW'(ALU_CYCLES - 1)) begin
          alu_nxt = '0;
          st_nxt  = ST_REGSTORE;
        end else begin
          alu_nxt = alu_cnt + AW'(1);
        end
      end
      ST_REGSTORE: st_nxt = ST_NEXT;
      ST_NEXT: begin
        st_nxt  = ST_FETCH;
        ret_nxt = ret_q + CNT_W'(1);
      end
      ST_HALT:  if (resume) st_nxt = ST_NEXT;
      ST_ERROR: st_nxt = ST_ERROR;
      default:  st_nxt = ST_ERROR;
    endcase
  end

  assign do_fetch    = (cur_st == ST_FETCH);
  assign do_regload  = (cur_st == ST_REGLOAD);
  assign do_aluop    = (cur_st == ST_ALUOP);
  assign do_load     = (cur_st == ST_LOAD);
  assign do_store    = (cur_st == ST_STORE);
  assign do_regstore = (cur_st == ST_REGSTORE);
  assign do_next     = (cur_st == ST_NEXT);
  assign mem_req     = do_fetch | do_load | do_store;
  assign halted      = (cur_st == ST_HALT);
  assign error       = (cur_st == ST_ERROR);
  assign err_code    = err_q;
  assign state       = cur_st;
  assign retired     = ret_q;

endmodule
